// File: rtl/rr_mux8_pkg.sv
// rtl/rr_mux8_pkg.sv - shared constants and helpers for the 8-lane round-robin mux
package rr_mux8_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Low bit position of lane idx inside a packed bus of dw-wide lanes.
  function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - picks the first eligible lane after the last served one
module rr_pick8
  import rr_mux8_pkg::*;
(
  input  logic [N_SRC-1:0] elig,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_start;
  logic [N_SRC-1:0] w_rot;
  logic [SEL_W-1:0] w_off;

  assign w_start = last + SEL_W'(1);

  // Rotate so bit 0 is the lane right after last; the 3-bit index wraps modulo 8.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_rot[i] = elig[w_start + SEL_W'(i)];
    end
  end

  always_comb begin
    w_off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign any = |elig;
  assign idx = w_start + w_off;

endmodule

// File: rtl/rr_mux8_arbiter.sv
// rtl/rr_mux8_arbiter.sv - round-robin burst scheduler sharing one output channel among 8 lanes
module rr_mux8_arbiter
  import rr_mux8_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC-1:0]    req_mask,
  input  logic [N_SRC*DW-1:0] data_in,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    out_src,
  output logic [N_SRC-1:0]    pop,
  output logic                busy
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;
  logic [3:0]       r_beat_cnt;

  logic [N_SRC-1:0] w_elig;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_busy;
  logic             w_valid;
  logic             w_accept;
  logic [DW-1:0]    w_lanes [N_SRC];
  logic [DW-1:0]    w_mux;

  assign w_elig = req & req_mask;

  rr_pick8 u_pick (
    .elig (w_elig),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  for (genvar g = 0; g < N_SRC; g++) begin : g_lane
    assign w_lanes[g] = data_in[lane_lo(g, DW) +: DW];
  end

  always_comb begin
    w_mux = '0;
    case (r_sel)
      3'd0: w_mux = w_lanes[0];
      3'd1: w_mux = w_lanes[1];
      3'd2: w_mux = w_lanes[2];
      3'd3: w_mux = w_lanes[3];
      3'd4: w_mux = w_lanes[4];
      3'd5: w_mux = w_lanes[5];
      3'd6: w_mux = w_lanes[6];
      3'd7: w_mux = w_lanes[7];
      default: w_mux = '0;
    endcase
  end

  // Valid follows the granted lane's request live; the mask only matters at arbitration.
  assign w_busy   = (r_state == BUSY);
  assign w_valid  = w_busy & req[r_sel];
  assign w_accept = w_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_last     <= SEL_W'(N_SRC - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel      <= w_idx;
            r_beat_cnt <= '0;
            r_state    <= BUSY;
          end
        end
        default: begin
          if (!req[r_sel]) begin
            r_last  <= r_sel;
            r_state <= IDLE;
          end else if (out_ready) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_last     <= r_sel;
              r_beat_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    pop        = '0;
    pop[r_sel] = w_accept;
  end

  assign out_data  = w_busy ? w_mux : '0;
  assign out_valid = w_valid;
  assign out_src   = r_sel;
  assign busy      = w_busy;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb/tb_rr_mux8_arbiter.sv - randomized model-checked bench for rr_mux8_arbiter
module tb_rr_mux8_arbiter;

  localparam int DW = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  req_mask;
  logic [31:0] data_in;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_src;
  logic [7:0]  pop;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  bit m_busy;
  int m_sel, m_last, m_beats, m_c;
  bit e_valid, e_accept;
  int m_grants[$];

  int npop, n, prev;
  bit ok;
  logic [3:0] rot_data [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'h7, 4'hF};

  rr_mux8_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_mask  (req_mask),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .pop       (pop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] lane(input int i);
    return data_in[i*4 +: 4];
  endfunction

  // Reference: grant goes to the first eligible lane after the last served one,
  // a grant lasts until MB beats are taken or its request drops.
  initial begin
    m_busy = 0; m_sel = 0; m_last = 7; m_beats = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_sel = 0; m_last = 7; m_beats = 0;
      end
      e_valid  = m_busy && req[m_sel];
      e_accept = e_valid && out_ready;
      check("m_busy", busy, m_busy);
      check("m_out_valid", out_valid, e_valid);
      check("m_pop", pop, e_accept ? (32'h1 << m_sel) : 32'h0);
      check("m_out_src", out_src, m_sel);
      check("m_out_data", out_data, m_busy ? lane(m_sel) : 4'h0);
      if (rst_n) begin
        if (!m_busy) begin
          for (int k = 1; k <= 8; k++) begin
            m_c = (m_last + k) % 8;
            if (req[m_c] && req_mask[m_c]) begin
              m_busy = 1; m_sel = m_c; m_beats = 0;
              m_grants.push_back(m_c);
              break;
            end
          end
        end else if (!req[m_sel]) begin
          m_last = m_sel; m_busy = 0;
        end else if (out_ready) begin
          m_beats++;
          if (m_beats == MB) begin
            m_last = m_sel; m_busy = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, output bit got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        got = 1;
        break;
      end
    end
    if (!got) check(name, busy, 1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_mask = '0; out_ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pop", pop, 0);
    check("rst_src", out_src, 0);
    check("rst_data", out_data, 0);

    // first grant after reset
    tick();
    rst_n = 1'b1; data_in = 32'h0000_0001; req = 8'h01; req_mask = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    check("t1_arb_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_pop", pop, 8'h01);
      check("t1_data", out_data, 4'h1);
    end
    @(negedge clk);
    check("t1_idle_gap", busy, 0);
    @(negedge clk);
    check("t1_regrant", busy, 1);

    // full rotation
    tick();
    req = '0;
    do_reset();
    m_grants.delete();
    data_in = 32'hF7EC_8421; req = 8'hFF; req_mask = 8'hFF; out_ready = 1'b1;
    n = 0; prev = 0;
    for (int cyc = 0; cyc < 80 && n < 9; cyc++) begin
      @(negedge clk);
      if (busy && prev == 0) begin
        check("t2_src", out_src, n % 8);
        check("t2_data", out_data, rot_data[n % 8]);
        n++;
      end
      prev = busy;
    end
    if (n < 9) check("t2_grant_count", n, 9);
    check("t2_model_count", m_grants.size() >= 9, 1);
    if (m_grants.size() >= 9)
      for (int i = 0; i < 9; i++) check("t2_model_order", m_grants[i], i % 8);

    // backpressure on lane 3
    tick();
    req = '0;
    do_reset();
    data_in = 32'h7654_3210; req = 8'h08;
    wait_grant("t3_grant_timeout", ok);
    check("t3_src", out_src, 3);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_pop", pop, 0);
      check("t3_hold_src", out_src, 3);
      check("t3_hold_data", out_data, 4'h3);
      check("t3_hold_valid", out_valid, 1);
    end
    tick();
    out_ready = 1'b1;
    npop = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (pop[3]) npop++;
      if (!busy) break;
    end
    check("t3_total_pops", npop, 4);

    // early release of lane 5
    tick();
    req = '0;
    do_reset();
    req = 8'hA0;
    wait_grant("t4_grant_timeout", ok);
    check("t4_src", out_src, 5);
    tick();
    @(negedge clk);
    check("t4_pop2", pop, 8'h20);
    tick();
    req = 8'h80;
    @(negedge clk);
    check("t4_drop_busy", busy, 1);
    check("t4_drop_valid", out_valid, 0);
    check("t4_drop_pop", pop, 0);
    @(negedge clk);
    check("t4_idle", busy, 0);
    @(negedge clk);
    check("t4_next_busy", busy, 1);
    check("t4_next_src", out_src, 7);

    // masking
    tick();
    req = '0;
    do_reset();
    req = 8'h05; req_mask = 8'h04;
    wait_grant("t5_grant_timeout", ok);
    check("t5_src", out_src, 2);
    tick();
    req_mask = 8'h00;
    npop = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (pop[2]) npop++;
      if (!busy) break;
    end
    check("t5_pops", npop, 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_grant", busy, 0);
    end

    // asynchronous reset mid-burst
    tick();
    req = '0; req_mask = 8'hFF;
    do_reset();
    req = 8'hFF;
    wait_grant("t6_grant_timeout", ok);
    tick();
    #2;
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_pop", pop, 0);
    check("t6_async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    wait_grant("t6_regrant_timeout", ok);
    check("t6_regrant_src", out_src, 0);

    // random traffic against the model
    tick();
    req = '0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      tick();
      req       = req ^ (8'($urandom) & 8'($urandom));
      req_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = $urandom;
      if (i % 400 == 399) do_reset();
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
